// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: a 2-note rising chirp on score, a 3-note falling tune on hit.
// Optional macro SFX_MUTE_EN adds a mute input that gates audioOut without disturbing note timing.
module sfx_sequencer #(
    parameter int unsigned NOTE_CYCLES = 5_000_000,
    parameter int unsigned SC_HALF0    = 56_818,
    parameter int unsigned SC_HALF1    = 37_908,
    parameter int unsigned HT_HALF0    = 113_636,
    parameter int unsigned HT_HALF1    = 151_515,
    parameter int unsigned HT_HALF2    = 227_273
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       score_evt,
    input  logic       hit_evt,
`ifdef SFX_MUTE_EN
    input  logic       mute,
`endif
    output logic       audioOut,
    output logic       busy,
    output logic [1:0] sfx_id,
    output logic [1:0] note_idx
);

    typedef enum logic [2:0] {StIdle, StSc0, StSc1, StHt0, StHt1, StHt2} state_e;

    localparam logic [22:0] DurLast  = 23'(NOTE_CYCLES - 1);
    localparam logic [17:0] ScLast0  = 18'(SC_HALF0 - 1);
    localparam logic [17:0] ScLast1  = 18'(SC_HALF1 - 1);
    localparam logic [17:0] HtLast0  = 18'(HT_HALF0 - 1);
    localparam logic [17:0] HtLast1  = 18'(HT_HALF1 - 1);
    localparam logic [17:0] HtLast2  = 18'(HT_HALF2 - 1);

    state_e      state_q, state_d;
    logic        score_q, hit_q;
    logic [22:0] dur_cnt_q, dur_cnt_d;
    logic [17:0] tone_cnt_q, tone_cnt_d;
    logic        tone_q, tone_d;
    logic        audio_q, audio_d;
    logic [17:0] half_last;
    logic        score_rise, hit_rise, dur_done, note_start;

    assign score_rise = score_evt & ~score_q;
    assign hit_rise   = hit_evt & ~hit_q;
    assign dur_done   = (dur_cnt_q == DurLast);

    always_comb begin
        half_last = '0;
        unique case (state_q)
            StSc0:   half_last = ScLast0;
            StSc1:   half_last = ScLast1;
            StHt0:   half_last = HtLast0;
            StHt1:   half_last = HtLast1;
            StHt2:   half_last = HtLast2;
            default: half_last = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dur_cnt_d  = dur_cnt_q + 23'd1;
        tone_cnt_d = tone_cnt_q + 18'd1;
        tone_d     = tone_q;
        note_start = 1'b0;
        if (tone_cnt_q == half_last) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end
        unique case (state_q)
            StIdle: begin
                if (hit_rise) begin
                    state_d    = StHt0;
                    note_start = 1'b1;
                end else if (score_rise) begin
                    state_d    = StSc0;
                    note_start = 1'b1;
                end
            end
            StSc0, StSc1: begin
                // hit preempts score; a fresh score edge restarts the chirp
                if (hit_rise) begin
                    state_d    = StHt0;
                    note_start = 1'b1;
                end else if (score_rise) begin
                    state_d    = StSc0;
                    note_start = 1'b1;
                end else if (dur_done) begin
                    if (state_q == StSc0) begin
                        state_d    = StSc1;
                        note_start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHt0: begin
                if (dur_done) begin
                    state_d    = StHt1;
                    note_start = 1'b1;
                end
            end
            StHt1: begin
                if (dur_done) begin
                    state_d    = StHt2;
                    note_start = 1'b1;
                end
            end
            StHt2: begin
                if (dur_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (note_start) begin
            dur_cnt_d  = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b1;
        end else if (state_d == StIdle) begin
            dur_cnt_d  = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
    end

`ifdef SFX_MUTE_EN
    assign audio_d = tone_d & ~mute;
`else
    assign audio_d = tone_d;
`endif

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            score_q    <= 1'b0;
            hit_q      <= 1'b0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            audio_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_evt;
            hit_q      <= hit_evt;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            audio_q    <= audio_d;
        end
    end

    assign audioOut = audio_q;

    always_comb begin
        busy     = (state_q != StIdle);
        sfx_id   = 2'b00;
        note_idx = 2'd0;
        unique case (state_q)
            StSc0: begin sfx_id = 2'b01; note_idx = 2'd0; end
            StSc1: begin sfx_id = 2'b01; note_idx = 2'd1; end
            StHt0: begin sfx_id = 2'b10; note_idx = 2'd0; end
            StHt1: begin sfx_id = 2'b10; note_idx = 2'd1; end
            StHt2: begin sfx_id = 2'b10; note_idx = 2'd2; end
            default: begin sfx_id = 2'b00; note_idx = 2'd0; end
        endcase
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random event traffic, checked every cycle
// against a sequence-level model (which effect, which note, cycles elapsed in the note).
module tb_sfx_sequencer;

    localparam int NoteCycles = 20;

    logic       ClkPort = 1'b0;
    logic       Reset = 1'b0;
    logic       score_evt = 1'b0;
    logic       hit_evt = 1'b0;
    logic       mute = 1'b0;
    logic       audioOut;
    logic       busy;
    logic [1:0] sfx_id;
    logic [1:0] note_idx;

    int n_checks = 0;
    int n_errors = 0;

    // model: kind 0 idle, 1 score, 2 hit
    int m_kind = 0;
    int m_note = 0;
    int m_elapsed = 0;
    bit m_ps = 1'b0;
    bit m_ph = 1'b0;
    bit m_mute = 1'b0;

    sfx_sequencer #(
        .NOTE_CYCLES(NoteCycles),
        .SC_HALF0   (2),
        .SC_HALF1   (3),
        .HT_HALF0   (4),
        .HT_HALF1   (5),
        .HT_HALF2   (6)
    ) dut (
        .ClkPort  (ClkPort),
        .Reset    (Reset),
        .score_evt(score_evt),
        .hit_evt  (hit_evt),
`ifdef SFX_MUTE_EN
        .mute     (mute),
`endif
        .audioOut (audioOut),
        .busy     (busy),
        .sfx_id   (sfx_id),
        .note_idx (note_idx)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int half_of(input int kind, input int note);
        if (kind == 1) return (note == 0) ? 2 : 3;
        return 4 + note;
    endfunction

    function automatic int notes_of(input int kind);
        return (kind == 1) ? 2 : 3;
    endfunction

    task automatic check_outputs();
        int exp_audio;
        exp_audio = 0;
        if (m_kind != 0 && !m_mute)
            exp_audio = ((m_elapsed / half_of(m_kind, m_note)) % 2 == 0) ? 1 : 0;
        check_val("busy", int'(busy), (m_kind != 0) ? 1 : 0);
        check_val("sfx_id", int'(sfx_id), m_kind);
        check_val("note_idx", int'(note_idx), m_note);
        check_val("audioOut", int'(audioOut), exp_audio);
    endtask

    // Advance model over one clock edge using the inputs currently applied, then compare.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            bit rs, rh;
            rs = score_evt && !m_ps;
            rh = hit_evt && !m_ph;
            m_ps = score_evt;
            m_ph = hit_evt;
`ifdef SFX_MUTE_EN
            m_mute = mute;
`endif
            if (rh && m_kind != 2) begin
                m_kind = 2; m_note = 0; m_elapsed = 0;
            end else if (rs && m_kind != 2) begin
                m_kind = 1; m_note = 0; m_elapsed = 0;
            end else if (m_kind != 0) begin
                m_elapsed++;
                if (m_elapsed == NoteCycles) begin
                    m_elapsed = 0;
                    m_note++;
                    if (m_note == notes_of(m_kind)) begin
                        m_kind = 0;
                        m_note = 0;
                    end
                end
            end
            @(posedge ClkPort);
            #1;
            check_outputs();
        end
    endtask

    // Asserts reset between edges so the asynchronous clear is visible before any clock.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        #1;
        check_val("rst_audio", int'(audioOut), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_sfx", int'(sfx_id), 0);
        check_val("rst_note", int'(note_idx), 0);
        m_kind = 0; m_note = 0; m_elapsed = 0;
        m_ps = 1'b0; m_ph = 1'b0; m_mute = 1'b0;
        score_evt = 1'b0;
        hit_evt = 1'b0;
        @(posedge ClkPort);
        #1;
        check_outputs();
        Reset = 1'b0;
    endtask

    initial begin
        #2;
        Reset = 1'b1;
        #1;
        check_outputs();
        @(posedge ClkPort);
        #1;
        Reset = 1'b0;
        check_outputs();
        tick(2);

        // 1: long score level plays a single chirp
        score_evt = 1'b1;
        tick();
        check_val("t1_sfx", int'(sfx_id), 1);
        tick(49);
        score_evt = 1'b0;
        tick(10);
        check_val("t1_idle", int'(busy), 0);

        // 2: held hit plays the tune once, no retrigger
        hit_evt = 1'b1;
        tick(75);
        check_val("t2_idle_audio", int'(audioOut), 0);
        hit_evt = 1'b0;
        tick(2);

        // 3: score rise in the middle of the second chirp note restarts it
        score_evt = 1'b1;
        tick();
        score_evt = 1'b0;
        tick(30);
        score_evt = 1'b1;
        tick();
        check_val("t3_note", int'(note_idx), 0);
        check_val("t3_audio", int'(audioOut), 1);
        score_evt = 1'b0;
        tick(45);

        // 4: hit preempts score; score during hit tune is ignored
        score_evt = 1'b1;
        tick();
        score_evt = 1'b0;
        tick(5);
        hit_evt = 1'b1;
        tick();
        check_val("t4_sfx", int'(sfx_id), 2);
        tick(25);
        score_evt = 1'b1;
        tick();
        score_evt = 1'b0;
        tick(40);
        hit_evt = 1'b0;
        tick(2);

        // 5: simultaneous rises, hit wins
        score_evt = 1'b1;
        hit_evt = 1'b1;
        tick();
        check_val("t5_sfx", int'(sfx_id), 2);
        tick(70);
        score_evt = 1'b0;
        hit_evt = 1'b0;
        tick(2);

        // 6: reset in the second hit note, then a normal chirp
        hit_evt = 1'b1;
        tick(28);
        check_val("t6_note", int'(note_idx), 1);
        do_reset();
        score_evt = 1'b1;
        tick(45);
        score_evt = 1'b0;
        tick(2);

`ifdef SFX_MUTE_EN
        score_evt = 1'b1;
        tick(5);
        mute = 1'b1;
        tick(20);
        mute = 1'b0;
        tick(20);
        score_evt = 1'b0;
        tick(2);
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) score_evt = ~score_evt;
            if ($urandom_range(0, 99) == 0) hit_evt = ~hit_evt;
`ifdef SFX_MUTE_EN
            if ($urandom_range(0, 29) == 0) mute = ~mute;
`endif
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
